// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: word/byte-enable widths,
// FSM state encoding and the address error check.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the last stored word; high address bits must be zero.
    function automatic logic err_code(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with byte-enabled synchronous write and registered read.
// Contents are deliberately not reset.
module mem_word_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then pulses a single response carrying read data or an error flag.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        count;
    logic              lat_write;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              rdata_en;

    logic              accept;
    logic              enter_resp;
    logic              sel_write;
    logic [WORD_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              sel_err;
    logic              mem_we;
    logic              mem_re;
    logic [WORD_W-1:0] mem_rdata;

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the array is accessed on the accept edge itself, so the
    // live request is used in IDLE and the latched copy afterwards.
    always_comb begin
        sel_write  = lat_write;
        sel_addr   = lat_addr;
        sel_wdata  = lat_wdata;
        sel_be     = lat_be;
        enter_resp = 1'b0;
        if (state == S_IDLE) begin
            sel_write  = req_write;
            sel_addr   = req_addr;
            sel_wdata  = req_wdata;
            sel_be     = req_be;
            enter_resp = accept && (LATENCY == 1);
        end else if (state == S_WAIT) begin
            enter_resp = (count == 4'd1);
        end
    end

    assign sel_err = err_code(sel_addr, DEPTH_WORDS);
    assign mem_we  = enter_resp && sel_write && !sel_err;
    assign mem_re  = enter_resp && !sel_write && !sel_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_en   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            resp_valid <= enter_resp;
            resp_err   <= enter_resp && sel_err;
            rdata_en   <= mem_re;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        count     <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign resp_rdata = rdata_en ? mem_rdata : '0;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (sel_addr[IDX_W+1:2]),
        .be    (sel_be),
        .wdata (sel_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid_v = 2'b00;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;

    logic        ready0, ready1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  ready_v, rvalid_v, err_v;
    logic [31:0] rdata_v [2];

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;

    assign ready_v    = {ready1, ready0};
    assign rvalid_v   = {rvalid1, rvalid0};
    assign err_v      = {err1, err0};
    assign rdata_v[0] = rdata0;
    assign rdata_v[1] = rdata1;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rvalid0), .resp_rdata(rdata0), .resp_err(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_err(err1)
    );

    // Transaction model: 'left' counts edges until the instance is free again;
    // the response is visible during the last busy cycle and commits there.
    int          lat_of [2] = '{2, 1};
    int          left [2];
    logic [1:0]  m_ready, m_valid, m_err;
    logic [31:0] m_rdata [2];
    logic        p_write [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be [2];
    logic [31:0] mmem [2][DEPTH];
    logic        bad;
    int          word;

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_ready[k] = 1'b0;
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b0;
                m_rdata[k] = 32'h0;
                left[k]    = 0;
            end else begin
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b0;
                m_rdata[k] = 32'h0;
                if (left[k] > 0) begin
                    left[k]--;
                end else if (m_ready[k] && req_valid_v[k]) begin
                    p_write[k] = req_write;
                    p_addr[k]  = req_addr;
                    p_wdata[k] = req_wdata;
                    p_be[k]    = req_be;
                    left[k]    = lat_of[k];
                end
                m_ready[k] = (left[k] == 0);
                if (left[k] == 1) begin
                    bad = (p_addr[k] % 4 != 0) || (p_addr[k] >= 4 * DEPTH);
                    m_valid[k] = 1'b1;
                    m_err[k]   = bad;
                    if (!bad) begin
                        word = int'(p_addr[k] / 4);
                        if (p_write[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (p_be[k][b]) mmem[k][word][8*b +: 8] = p_wdata[k][8*b +: 8];
                        end else begin
                            m_rdata[k] = mmem[k][word];
                        end
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check_output($sformatf("dut%0d req_ready", k), 32'(ready_v[k]), 32'(m_ready[k]));
                check_output($sformatf("dut%0d resp_valid", k), 32'(rvalid_v[k]), 32'(m_valid[k]));
                check_output($sformatf("dut%0d resp_err", k), 32'(err_v[k]), 32'(m_err[k]));
                check_output($sformatf("dut%0d resp_rdata", k), rdata_v[k], m_rdata[k]);
            end
        end
    end

    task automatic apply_stimulus(input int k, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output logic [31:0] rd, output logic er, output int lat);
        int guard = 0;
        @(negedge clk);
        req_write      = wr;
        req_addr       = addr;
        req_wdata      = wdata;
        req_be         = be;
        req_valid_v[k] = 1'b1;
        while (!ready_v[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_wait dut%0d: got no req_ready, required within 20 cycles", k);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_v[k] = 1'b0;
        lat = 1;
        while (!rvalid_v[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata_v[k];
        er = err_v[k];
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int          pulses;

        reset = 1'b0;
        @(posedge clk);
        started = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("in_reset req_ready", 32'(ready0), 32'h0);
        #2 reset = 1'b1;
        @(negedge clk);
        check_output("post_reset req_ready", 32'(ready0), 32'h1);
        check_output("post_reset resp_valid", 32'(rvalid0), 32'h0);
        check_output("post_reset resp_err", 32'(err0), 32'h0);
        check_output("post_reset resp_rdata", rdata0, 32'h0);

        $display("[TB] full-word store and load");
        apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check_output("t2 store latency", lat, 32'd2);
        check_output("t2 store err", 32'(er), 32'h0);
        check_output("t2 store rdata", rd, 32'h0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_output("t2 load latency", lat, 32'd2);
        check_output("t2 load rdata", rd, 32'hDEADBEEF);
        check_output("t2 load err", 32'(er), 32'h0);

        $display("[TB] byte-enable store");
        apply_stimulus(0, 1'b1, 32'h10, 32'h00000055, 4'b0001, rd, er, lat);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_output("t3 load rdata", rd, 32'hDEADBE55);
        apply_stimulus(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check_output("noop store err", 32'(er), 32'h0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_output("noop store rdata", rd, 32'hDEADBE55);

        $display("[TB] error cases and last word");
        apply_stimulus(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        check_output("misaligned load err", 32'(er), 32'h1);
        check_output("misaligned load rdata", rd, 32'h0);
        apply_stimulus(0, 1'b1, 32'h400, 32'h11111111, 4'hF, rd, er, lat);
        check_output("range store 0x400 err", 32'(er), 32'h1);
        apply_stimulus(0, 1'b1, 32'h410, 32'h22222222, 4'hF, rd, er, lat);
        check_output("range store 0x410 err", 32'(er), 32'h1);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_output("t4 reload rdata", rd, 32'hDEADBE55);
        apply_stimulus(0, 1'b1, 32'h3FC, 32'hA5A50FF0, 4'hF, rd, er, lat);
        check_output("last word store err", 32'(er), 32'h0);
        apply_stimulus(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        check_output("last word load rdata", rd, 32'hA5A50FF0);

        $display("[TB] back-to-back requests, LATENCY=1");
        @(negedge clk);
        req_write      = 1'b1;
        req_addr       = 32'h20;
        req_wdata      = 32'h12345678;
        req_be         = 4'hF;
        req_valid_v[1] = 1'b1;
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready1) acc++;
            @(negedge clk);
            if (rvalid1) pulses++;
        end
        req_valid_v[1] = 1'b0;
        check_output("t5 accepts", acc, 32'd5);
        check_output("t5 resp pulses", pulses, 32'd5);
        apply_stimulus(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check_output("t5 load latency", lat, 32'd1);
        check_output("t5 load rdata", rd, 32'h12345678);

        $display("[TB] reset during wait");
        @(negedge clk);
        req_write      = 1'b1;
        req_addr       = 32'h10;
        req_wdata      = 32'h0BAD0BAD;
        req_be         = 4'hF;
        req_valid_v[0] = 1'b1;
        acc = 0;
        while (!ready0 && acc < 20) begin
            @(negedge clk);
            acc++;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid0) pulses++;
            @(negedge clk);
        end
        check_output("t6 aborted resp pulses", pulses, 32'd0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check_output("t6 reload rdata", rd, 32'hDEADBE55);
        check_output("t6 reload err", 32'(er), 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
